// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider with a single shared config slot, applied glitch-free at the channel wrap.
// Latency: clk_out/tick are registered one cycle behind the channel count; config lands at the target channel's wrap edge.
// Backpressure: cfg_ready is low while a config waits in the slot; requests are ignored until the slot drains.
module prog_clk_divider #(
    parameter int WIDTH       = 10,
    parameter int CHANNELS    = 2,
    parameter int DEFAULT_DIV = 1000
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              enable,
    input  logic                                              sync,
    input  logic                                              cfg_valid,
    output logic                                              cfg_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
    input  logic [WIDTH-1:0]                                  cfg_div,
    input  logic [WIDTH-1:0]                                  cfg_duty,
    output logic [CHANNELS-1:0]                               clk_out,
    output logic [CHANNELS-1:0]                               tick
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] RST_DUTY = WIDTH'(DEFAULT_DIV / 2);

    logic                pending;
    logic [CW-1:0]       sh_ch;
    logic [WIDTH-1:0]    sh_div;
    logic [WIDTH-1:0]    sh_duty;
    logic [CHANNELS-1:0] apply;
    logic                ch_ok;

    assign cfg_ready = ~pending;
    assign ch_ok     = (32'(cfg_ch) < 32'(CHANNELS));

    // Out-of-range channel requests complete the handshake but never occupy the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            sh_ch   <= '0;
            sh_div  <= '0;
            sh_duty <= '0;
        end else if (pending) begin
            if (|apply) begin
                pending <= 1'b0;
            end
        end else if (cfg_valid && ch_ok) begin
            pending <= 1'b1;
            sh_ch   <= cfg_ch;
            sh_div  <= cfg_div;
            sh_duty <= cfg_duty;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] count;
        logic [WIDTH-1:0] div;
        logic [WIDTH-1:0] duty;
        logic             out_q;
        logic             tick_q;
        logic             running;
        logic             last;
        logic             hit;

        assign running = enable && (div != '0);
        assign last    = running && (count == div - 1'b1);
        // A stopped or frozen channel has no wrap to wait for, so it takes the slot on the next edge.
        assign hit      = pending && (sh_ch == CW'(i)) && (last || sync || !running);
        assign apply[i] = hit;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count  <= '0;
                div    <= RST_DIV;
                duty   <= RST_DUTY;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                if (hit) begin
                    div   <= sh_div;
                    duty  <= sh_duty;
                    count <= '0;
                end else if (sync || last) begin
                    count <= '0;
                end else if (running) begin
                    count <= count + 1'b1;
                end
                tick_q <= last;
                if (enable) begin
                    out_q <= running && (count < duty);
                end
            end
        end

        assign clk_out[i] = out_q;
        assign tick[i]    = tick_q;
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider (WIDTH=10, CHANNELS=2, DEFAULT_DIV=8): vector table, directed corner sequences, random run vs reference model.
module tb_prog_clk_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       sync;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [0:0] cfg_ch;
    logic [9:0] cfg_div;
    logic [9:0] cfg_duty;
    logic [1:0] clk_out;
    logic [1:0] tick;

    int n_checks = 0;
    int n_fail   = 0;

    prog_clk_divider #(.WIDTH(10), .CHANNELS(2), .DEFAULT_DIV(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_duty(cfg_duty), .clk_out(clk_out), .tick(tick)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    // Reference model: per-channel period arithmetic plus one config slot.
    int m_cnt[2];
    int m_div[2];
    int m_duty[2];
    bit m_clk[2];
    bit m_tick[2];
    bit m_pend;
    bit m_acc;
    int m_sch;
    int m_sdiv;
    int m_sduty;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_div[i] = 8; m_duty[i] = 4; m_clk[i] = 0; m_tick[i] = 0;
        end
        m_pend = 0; m_acc = 0; m_sch = 0; m_sdiv = 0; m_sduty = 0;
    endtask

    task automatic model_step();
        bit landed = 0;
        for (int i = 0; i < 2; i++) begin
            bit period_end = enable && m_div[i] != 0 && m_cnt[i] == m_div[i] - 1;
            bit take = m_pend && m_sch == i && (period_end || sync || m_div[i] == 0 || !enable);
            m_tick[i] = period_end;
            if (enable) m_clk[i] = (m_div[i] != 0) && (m_cnt[i] < m_duty[i]);
            if (take) begin
                m_div[i] = m_sdiv; m_duty[i] = m_sduty; m_cnt[i] = 0; landed = 1;
            end else if (sync) begin
                m_cnt[i] = 0;
            end else if (enable) begin
                m_cnt[i] = (m_div[i] == 0) ? 0 : (m_cnt[i] + 1) % m_div[i];
            end
        end
        m_acc = cfg_valid && !m_pend;
        if (m_pend) begin
            if (landed) m_pend = 0;
        end else if (cfg_valid && int'(cfg_ch) < 2) begin
            m_pend = 1; m_sch = int'(cfg_ch); m_sdiv = int'(cfg_div); m_sduty = int'(cfg_duty);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are compared on the next falling edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        @(negedge clk);
        chk("model_clk_out", 32'(clk_out), 32'({m_clk[1], m_clk[0]}));
        chk("model_tick", 32'(tick), 32'({m_tick[1], m_tick[0]}));
        chk("model_cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cfg_ready && n < 50) begin
            step();
            n++;
        end
        chk("wait_ready_bound", 32'(cfg_ready), 32'(1));
    endtask

    task automatic send_cfg(input int ch, input int dv, input int dt);
        wait_ready();
        cfg_valid = 1'b1;
        cfg_ch    = 1'(ch);
        cfg_div   = 10'(dv);
        cfg_duty  = 10'(dt);
        step();
        cfg_valid = 1'b0;
    endtask

    typedef struct {
        logic       en;
        logic       syn;
        logic [1:0] exp_clk;
        logic [1:0] exp_tick;
        logic       exp_rdy;
    } vec_t;

    vec_t tbl[24];

    initial begin
        int ticks;
        // Default 8/4 on both channels: edge k sees count (k%8); then 4 frozen cycles; then resume.
        for (int k = 0; k < 16; k++) begin
            tbl[k].en       = 1'b1;
            tbl[k].syn      = 1'b0;
            tbl[k].exp_clk  = ((k % 8) < 4) ? 2'b11 : 2'b00;
            tbl[k].exp_tick = ((k % 8) == 7) ? 2'b11 : 2'b00;
            tbl[k].exp_rdy  = 1'b1;
        end
        for (int k = 16; k < 20; k++) tbl[k] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b1};
        for (int k = 20; k < 24; k++) tbl[k] = '{1'b1, 1'b0, 2'b11, 2'b00, 1'b1};

        rst_n = 1'b0; enable = 1'b1; sync = 1'b0; cfg_valid = 1'b0;
        cfg_ch = 1'b0; cfg_div = '0; cfg_duty = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_clk_out", 32'(clk_out), 32'(0));
        chk("reset_tick", 32'(tick), 32'(0));
        chk("reset_cfg_ready", 32'(cfg_ready), 32'(1));
        rst_n = 1'b1;

        for (int k = 0; k < 24; k++) begin
            enable = tbl[k].en;
            sync   = tbl[k].syn;
            step();
            chk("tbl_clk_out", 32'(clk_out), 32'(tbl[k].exp_clk));
            chk("tbl_tick", 32'(tick), 32'(tbl[k].exp_tick));
            chk("tbl_cfg_ready", 32'(cfg_ready), 32'(tbl[k].exp_rdy));
        end
        enable = 1'b1;

        // Mid-period reconfigure of ch0: slot stays busy until the old 8-period ends (counts 4..7).
        send_cfg(0, 5, 2);
        chk("cfg_busy_after_accept", 32'(cfg_ready), 32'(0));
        for (int j = 0; j < 3; j++) begin
            step();
            if (j < 2) chk("cfg_busy_old_period", 32'(cfg_ready), 32'(0));
        end
        chk("old_period_tick", 32'(tick[0]), 32'(1));
        chk("ready_after_wrap", 32'(cfg_ready), 32'(1));
        for (int k = 0; k < 10; k++) begin
            step();
            chk("div5_clk", 32'(clk_out[0]), 32'((k % 5) < 2));
            chk("div5_tick", 32'(tick[0]), 32'((k % 5) == 4));
        end

        // div=0 stops the channel.
        send_cfg(0, 0, 0);
        wait_ready();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("div0_clk", 32'(clk_out[0]), 32'(0));
            chk("div0_tick", 32'(tick[0]), 32'(0));
        end
        // div=1 duty=1: constant high, tick stuck high.
        send_cfg(0, 1, 1);
        wait_ready();
        for (int k = 0; k < 2; k++) begin
            step();
            chk("div1_clk", 32'(clk_out[0]), 32'(1));
            chk("div1_tick", 32'(tick[0]), 32'(1));
        end
        // div=6 duty=9: duty beyond period gives constant high, tick every 6.
        send_cfg(0, 6, 9);
        wait_ready();
        ticks = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("div6_clk", 32'(clk_out[0]), 32'(1));
            if (tick[0]) ticks++;
        end
        chk("div6_tick_count", 32'(ticks), 32'(2));

        // Different divisors, then sync aligns both phases.
        send_cfg(0, 4, 2);
        wait_ready();
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("sync_clk", 32'(clk_out), 32'({1'((k % 8) < 4), 1'((k % 4) < 2)}));
            chk("sync_tick", 32'(tick), 32'({1'((k % 8) == 7), 1'((k % 4) == 3)}));
        end

        // Freeze for 10 cycles with both counts at 3.
        repeat (3) step();
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("freeze_clk", 32'(clk_out), 32'(2'b10));
            chk("freeze_tick", 32'(tick), 32'(0));
        end
        enable = 1'b1;
        step();
        chk("resume_clk", 32'(clk_out), 32'(2'b10));
        chk("resume_tick", 32'(tick), 32'(2'b01));
        step();
        chk("resume_clk2", 32'(clk_out), 32'(2'b01));

        // Pending config on ch1 is dropped by a reset before its wrap.
        send_cfg(1, 3, 1);
        chk("pend_before_reset", 32'(cfg_ready), 32'(0));
        rst_n = 1'b0;
        #1;
        chk("async_reset_clk", 32'(clk_out), 32'(0));
        chk("async_reset_tick", 32'(tick), 32'(0));
        chk("async_reset_ready", 32'(cfg_ready), 32'(1));
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            chk("post_reset_clk", 32'(clk_out), 32'(((k % 8) < 4) ? 2'b11 : 2'b00));
            chk("post_reset_tick", 32'(tick), 32'(((k % 8) == 7) ? 2'b11 : 2'b00));
        end

        // Random traffic; a refused request is held until it transfers.
        for (int c = 0; c < 3000; c++) begin
            enable = ($urandom_range(0, 9) != 0);
            sync   = ($urandom_range(0, 49) == 0);
            if (cfg_valid && m_acc) cfg_valid = 1'b0;
            if (!cfg_valid && $urandom_range(0, 5) == 0) begin
                cfg_valid = 1'b1;
                cfg_ch    = 1'($urandom_range(0, 1));
                cfg_div   = 10'($urandom_range(0, 12));
                cfg_duty  = 10'($urandom_range(0, 14));
            end
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
